uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- On-chip boot loader that receives the program image over a UART serial line and writes it into instruction memory.
- Deserializes 8N1 bytes and assembles them MSB-first into 32-bit words.
- Writes each word to sequential word addresses and stops at the end-of-image marker 0x00000FFF.
- Holds the user core in reset while loading and releases it only after a clean load. It is the on-chip counterpart of the UART program-feed bench.

Parameters:
- CLKS_PER_BIT, 696: clk cycles per UART bit. Legal values are 4 or more.
- ADDR_W, 12: instruction memory word-address width.
- MEM_DEPTH, 4096: number of writable words. Must be no more than 2^ADDR_W.
- END_WORD, 32'h00000FFF: end-of-image marker word.

Ports:
- clk  in  1  system clock; the block has one clock domain.
- rst_n  in  1  asynchronous active-low reset.
- prog_en  in  1  loading enable, driven by the mprj_ready-style strap/handshake.
- rx  in  1  UART serial input. Asynchronous; the block synchronizes it internally.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  assembled instruction word.
- core_rst_n  out  1  active-low reset to the user core.
- loading  out  1  high while in LOAD.
- prog_done  out  1  high in DONE.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overflow  out  1  sticky: MEM_DEPTH words were written before END_WORD arrived.
- word_count  out  ADDR_W+1  number of words written in the current load.

Behaviour:
- Reset values, asynchronous on rst_n low:
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - core_rst_n=0, loading=0, prog_done=0, frame_err=0, overflow=0, word_count=0.
  - Top FSM = IDLE, RX FSM = RX_IDLE.
  - rx synchronizer flops are preset to 1.
- rx synchronization: 2-flop synchronizer. All rx decisions below use the synchronized value.
- Top FSM:
  - IDLE:
    - core_rst_n=0.
    - On the rising edge of prog_en: go to LOAD and clear word_count, byte counter, frame_err and overflow.
  - LOAD:
    - loading=1, core_rst_n=0.
    - prog_en low: abort to IDLE the next cycle. A partial word is discarded, no write is issued, and word_count holds its value.
  - DONE:
    - prog_done=1, core_rst_n=1.
    - Exits only on rst_n, or on a new rising edge of prog_en, which goes to LOAD as above.
- RX FSM runs only in LOAD; it is forced to RX_IDLE otherwise.
  - RX_IDLE: a 1 to 0 transition on the synchronized rx goes to RX_START and clears the bit timer.
  - RX_START:
    - At timer = CLKS_PER_BIT/2 (integer division), sample rx.
    - Sample is 1: false start, return to RX_IDLE.
    - Sample is 0: clear the timer and go to RX_DATA.
  - RX_DATA:
    - Sample at each timer = CLKS_PER_BIT-1, LSB first, 8 bits.
    - After bit 7, go to RX_STOP.
  - RX_STOP:
    - Sample at timer = CLKS_PER_BIT-1.
    - Sample is 1: byte is valid for one cycle.
    - Sample is 0: set frame_err and discard the byte.
    - In both cases return to RX_IDLE.
- Word assembly:
  - The shift register shifts left 8 bits per valid byte, so the first byte received is word[31:24].
  - The byte counter counts 0..3 and wraps after the 4th valid byte.
- On the 4th byte, one cycle after byte valid:
  - Word equals END_WORD: no write, go to DONE.
  - Otherwise:
    - Assert imem_we for exactly one cycle with imem_addr = word_count[ADDR_W-1:0] and imem_wdata = word.
    - word_count increments in the same cycle.
    - If word_count reaches MEM_DEPTH: set overflow and go to DONE. core_rst_n stays 0 in this case; it is released only for loads that end on END_WORD.
- imem_addr and imem_wdata hold their last values when imem_we is 0.
- Bytes that arrive while in DONE or IDLE are ignored.
- A frame error does not abort the load. Only the corrupted byte is dropped, and the byte counter does not advance for it.
- Reset mid-frame: all state returns to the reset values immediately; no write is issued.

Test Plan:
- Basic load (CLKS_PER_BIT=16, prog_en rising):
  - Stimulus: bytes 13 05 00 93, then DE AD BE EF, then 00 00 0F FF.
  - Required: write addr 0 data 0x13050093, then write addr 1 data 0xDEADBEEF.
  - Required: prog_done=1, core_rst_n=1, word_count=2, and no write for the marker.
- Write latency: imem_we is high for exactly 1 cycle, 1 cycle after the stop-bit sample of the 4th byte.
- False start: a 0 pulse shorter than CLKS_PER_BIT/2 on rx leaves the RX FSM in RX_IDLE with no byte, and the byte counter stays 0.
- Frame error:
  - Stimulus: byte AA sent with its stop bit driven 0, then 11 22 33 44.
  - Required: frame_err=1, one write of 0x11223344 at addr 0.
- Overflow (MEM_DEPTH=4): send 5 non-marker words.
  - Required: 4 writes at addr 0..3, then overflow=1, prog_done=1, core_rst_n=0, and no 5th write.
- Abort and reset:
  - Drop prog_en after 2 bytes of a word. Required: IDLE, no write.
  - Then raise prog_en and send one full word plus the marker. Required: write at addr 0.
  - Assert rst_n low mid-byte. Required: all outputs at their reset values immediately.

Source files
------------

// File: rtl/uart_prog_loader_if.sv
// Boot loader bus: strap/serial inputs, imem write port and status.
// The loader is the master; the environment is the slave.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 12
);
  logic              prog_en;
  logic              rx;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              loading;
  logic              prog_done;
  logic              frame_err;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  modport master (
    input  prog_en,
    input  rx,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output core_rst_n,
    output loading,
    output prog_done,
    output frame_err,
    output overflow,
    output word_count
  );

  modport slave (
    output prog_en,
    output rx,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  core_rst_n,
    input  loading,
    input  prog_done,
    input  frame_err,
    input  overflow,
    input  word_count
  );
endinterface

// File: rtl/uart_prog_loader.sv
// UART boot loader: 8N1 bytes -> MSB-first words -> imem writes.
// Holds the user core in reset until a load ends on END_WORD.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 696,
  parameter int          ADDR_W       = 12,
  parameter int          MEM_DEPTH    = 4096,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input logic               clk,
  input logic               rst_n,
  uart_prog_loader_if.master bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF =
    TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_LAST =
    TW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } top_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_e;

  top_e st_q, st_d;
  rx_e  rx_st_q, rx_st_d;

  logic          s1_q, s2_q, prev_q;
  logic          pe_q;
  logic          pe_rise;

  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          rx_vld;
  logic          rx_ferr;

  logic [31:0]       word_q, word_d;
  logic [1:0]        bc_q, bc_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;

  assign pe_rise = bus.prog_en & ~pe_q;

  // rx synchronizer, rx edge history and prog_en edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      pe_q   <= 1'b0;
    end else begin
      s1_q   <= bus.rx;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      pe_q   <= bus.prog_en;
    end
  end

  // RX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q <= RX_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
    end else begin
      rx_st_q <= rx_st_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
    end
  end

  // RX FSM next state; only live while loading
  always_comb begin
    rx_st_d = rx_st_q;
    tmr_d   = tmr_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    rx_vld  = 1'b0;
    rx_ferr = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        tmr_d = '0;
        if (prev_q && !s2_q) rx_st_d = RX_START;
      end
      RX_START: begin
        if (tmr_q == T_HALF) begin
          tmr_d   = '0;
          bit_d   = '0;
          rx_st_d = s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tmr_q == T_LAST) begin
          tmr_d  = '0;
          byte_d = {s2_q, byte_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tmr_q == T_LAST) begin
          tmr_d   = '0;
          rx_st_d = RX_IDLE;
          rx_vld  = s2_q;
          rx_ferr = ~s2_q;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
    if (st_q != ST_LOAD) begin
      rx_st_d = RX_IDLE;
      tmr_d   = '0;
      rx_vld  = 1'b0;
      rx_ferr = 1'b0;
    end
  end

  // top FSM, word assembly and write port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      word_q  <= '0;
      bc_q    <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      word_q  <= word_d;
      bc_q    <= bc_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  // top FSM next state; abort wins over a byte landing
  always_comb begin
    st_d    = st_q;
    word_d  = word_q;
    bc_d    = bc_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ferr_d  = ferr_q;
    ovf_d   = ovf_q;
    unique case (st_q)
      ST_IDLE, ST_DONE: begin
        if (pe_rise) begin
          st_d   = ST_LOAD;
          word_d = '0;
          bc_d   = '0;
          wc_d   = '0;
          ferr_d = 1'b0;
          ovf_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (!bus.prog_en) begin
          st_d = ST_IDLE;
        end else begin
          if (rx_ferr) ferr_d = 1'b1;
          if (rx_vld) begin
            word_d = {word_q[23:0], byte_q};
            bc_d   = bc_q + 2'd1;
            if (bc_q == 2'd3) begin
              if (word_d == END_WORD) begin
                st_d = ST_DONE;
              end else begin
                we_d    = 1'b1;
                addr_d  = wc_q[ADDR_W-1:0];
                wdata_d = word_d;
                wc_d    = wc_q + 1'b1;
                if (wc_d == DEPTH) begin
                  ovf_d = 1'b1;
                  st_d  = ST_DONE;
                end
              end
            end
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.loading    = (st_q == ST_LOAD);
  assign bus.prog_done  = (st_q == ST_DONE);
  assign bus.core_rst_n = (st_q == ST_DONE) & ~ovf_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf_q;
  assign bus.word_count = wc_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: 16 clk/bit, 4-word memory.
// Table-driven basic load plus directed corner sequences.
module tb_uart_prog_loader;

  logic clk;
  logic rst_n;

  uart_prog_loader_if #(.ADDR_W(12)) bus ();

  uart_prog_loader #(
    .CLKS_PER_BIT(16),
    .ADDR_W(12),
    .MEM_DEPTH(4),
    .END_WORD(32'h0000_0FFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int last_we_k;
  int width_err = 0;
  int base;
  logic we_prev = 1'b0;
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];

  typedef struct {
    logic [31:0] word;
    int          exp_nwr;
    logic [11:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_k;
  } vec_t;

  vec_t tbl[3];

  // write monitor and strobe width watch
  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
    if (bus.imem_we && we_prev) width_err <= width_err + 1;
    we_prev <= bus.imem_we;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic check_wr(input string name, input int idx,
                          input logic [11:0] a,
                          input logic [31:0] d);
    if (idx >= wr_addr.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: write %0d missing, got %0d writes",
               name, idx, wr_addr.size());
    end else begin
      check({name, "_addr"}, {20'd0, wr_addr[idx]}, {20'd0, a});
      check({name, "_data"}, wr_data[idx], d);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_we"}, {31'd0, bus.imem_we}, 0);
    check({name, "_addr"}, {20'd0, bus.imem_addr}, 0);
    check({name, "_wdata"}, bus.imem_wdata, 0);
    check({name, "_crst"}, {31'd0, bus.core_rst_n}, 0);
    check({name, "_load"}, {31'd0, bus.loading}, 0);
    check({name, "_done"}, {31'd0, bus.prog_done}, 0);
    check({name, "_ferr"}, {31'd0, bus.frame_err}, 0);
    check({name, "_ovf"}, {31'd0, bus.overflow}, 0);
    check({name, "_wc"}, {19'd0, bus.word_count}, 0);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    last_we_k = -1;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (bus.imem_we) last_we_k = k;
      bus.rx = fr[k/16];
    end
    if (!stop) begin
      @(negedge clk);
      bus.rx = 1'b1;
      repeat (32) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic restart();
    bus.prog_en = 1'b0;
    repeat (3) @(negedge clk);
    bus.prog_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{32'h1305_0093, 1, 12'd0, 32'h1305_0093, 156};
    tbl[1] = '{32'hDEAD_BEEF, 1, 12'd1, 32'hDEAD_BEEF, 156};
    tbl[2] = '{32'h0000_0FFF, 0, 12'd0, 32'h0,         -1};

    rst_n = 1'b0;
    bus.prog_en = 1'b0;
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_load", {31'd0, bus.loading}, 0);
    bus.prog_en = 1'b1;
    repeat (2) @(negedge clk);
    check("enter_load", {31'd0, bus.loading}, 1);

    bus.rx = 1'b0;
    repeat (5) @(negedge clk);
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    check("fstart_nwr", wr_addr.size(), 0);
    check("fstart_ferr", {31'd0, bus.frame_err}, 0);

    for (int i = 0; i < 3; i++) begin
      base = wr_addr.size();
      send_word(tbl[i].word);
      check("basic_nwr", wr_addr.size() - base, tbl[i].exp_nwr);
      if (tbl[i].exp_nwr != 0)
        check_wr("basic_wr", base, tbl[i].exp_addr, tbl[i].exp_data);
      check("basic_lat", last_we_k, tbl[i].exp_k);
    end
    check("basic_done", {31'd0, bus.prog_done}, 1);
    check("basic_crst", {31'd0, bus.core_rst_n}, 1);
    check("basic_load", {31'd0, bus.loading}, 0);
    check("basic_wc", {19'd0, bus.word_count}, 2);
    check("basic_ovf", {31'd0, bus.overflow}, 0);

    base = wr_addr.size();
    send_word(32'h0102_0304);
    check("done_ignore", wr_addr.size() - base, 0);
    check("done_wc", {19'd0, bus.word_count}, 2);

    restart();
    check("fe_wc0", {19'd0, bus.word_count}, 0);
    check("fe_crst", {31'd0, bus.core_rst_n}, 0);
    base = wr_addr.size();
    send_byte(8'hAA, 1'b0);
    check("fe_flag", {31'd0, bus.frame_err}, 1);
    check("fe_still_load", {31'd0, bus.loading}, 1);
    send_word(32'h1122_3344);
    check("fe_nwr", wr_addr.size() - base, 1);
    check_wr("fe_wr", base, 12'd0, 32'h1122_3344);
    check("fe_sticky", {31'd0, bus.frame_err}, 1);

    restart();
    check("ov_ferr_clr", {31'd0, bus.frame_err}, 0);
    base = wr_addr.size();
    for (int i = 0; i < 5; i++) begin
      send_word(32'hA000_0000 | i);
      if (i < 4)
        check_wr("ov_wr", base + i, 12'(i), 32'hA000_0000 | i);
      if (i == 3) begin
        check("ov_flag", {31'd0, bus.overflow}, 1);
        check("ov_done", {31'd0, bus.prog_done}, 1);
        check("ov_crst", {31'd0, bus.core_rst_n}, 0);
        check("ov_wc", {19'd0, bus.word_count}, 4);
      end
    end
    check("ov_nwr", wr_addr.size() - base, 4);

    restart();
    base = wr_addr.size();
    send_byte(8'hC0, 1'b1);
    send_byte(8'hDE, 1'b1);
    bus.prog_en = 1'b0;
    repeat (2) @(negedge clk);
    check("ab_load", {31'd0, bus.loading}, 0);
    check("ab_done", {31'd0, bus.prog_done}, 0);
    check("ab_wc", {19'd0, bus.word_count}, 0);
    bus.prog_en = 1'b1;
    repeat (2) @(negedge clk);
    send_word(32'h1234_5678);
    send_word(32'h0000_0FFF);
    check("ab_nwr", wr_addr.size() - base, 1);
    check_wr("ab_wr", base, 12'd0, 32'h1234_5678);
    check("ab_fin_done", {31'd0, bus.prog_done}, 1);
    check("ab_fin_crst", {31'd0, bus.core_rst_n}, 1);
    check("ab_fin_wc", {19'd0, bus.word_count}, 1);

    restart();
    base = wr_addr.size();
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    bus.prog_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("mrst");
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    check("mrst_nwr", wr_addr.size() - base, 0);
    check("we_width", width_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
